// File: rtl/huffman_decoder.sv
// Canonical Huffman symbol decoder: one stream bit per cycle, per-length range match, table read by code value.
// Optional macro HUFF_ERR_EN adds a sticky ERR state for codes that match nothing at length 15.
module huffman_decoder #(
    parameter int ADDR_BIT  = 7,
    parameter int INDEX_BIT = 9,
    parameter int CODE_BIT  = 15,
    parameter int LEN_BIT   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   table_ready,
    input  logic [16*CODE_BIT-1:0] first_codes,
    input  logic [16*CODE_BIT-1:0] limit_codes,
    input  logic [CODE_BIT-1:0]    eob_code,
    input  logic [LEN_BIT-1:0]     eob_length,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [ADDR_BIT-1:0]    table_addr,
    output logic                   table_ena,
    output logic                   table_wea,
    input  logic [INDEX_BIT-1:0]   table_douta,
    output logic [INDEX_BIT-1:0]   sym_data,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic                   sym_last,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_READ,
        ST_CAPT,
        ST_EMIT,
        ST_DONE
`ifdef HUFF_ERR_EN
        , ST_ERR
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [CODE_BIT-1:0]   code_q, code_d;
    logic [LEN_BIT-1:0]    len_q, len_d;
    logic [ADDR_BIT-1:0]   addr_q, addr_d;
    logic [INDEX_BIT-1:0]  symData_q, symData_d;
    logic                  symValid_q, symValid_d;
    logic                  symLast_q, symLast_d;

    logic                  accept;
    logic [CODE_BIT-1:0]   nextCode;
    logic [LEN_BIT-1:0]    nextLen;
    logic [CODE_BIT-1:0]   firstSel;
    logic [CODE_BIT-1:0]   limitSel;
    logic                  eobHit;
    logic                  tableHit;
    logic                  maxLen;

    // The candidate code includes the bit being accepted, so a match is decided in the same cycle.
    assign accept   = bit_valid && bit_ready;
    assign nextCode = {code_q[CODE_BIT-2:0], bit_in};
    assign nextLen  = len_q + LEN_BIT'(1);
    assign firstSel = first_codes[int'(nextLen)*CODE_BIT +: CODE_BIT];
    assign limitSel = limit_codes[int'(nextLen)*CODE_BIT +: CODE_BIT];
    assign eobHit   = (nextLen == eob_length) && (nextCode == eob_code);
    assign tableHit = (nextCode >= firstSel) && (nextCode < limitSel);
    assign maxLen   = (nextLen == LEN_BIT'(15));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            symData_q  <= '0;
            symValid_q <= 1'b0;
            symLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            symData_q  <= symData_d;
            symValid_q <= symValid_d;
            symLast_q  <= symLast_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        len_d      = len_q;
        addr_d     = addr_q;
        symData_d  = symData_q;
        symValid_d = symValid_q;
        symLast_d  = symLast_q;
        case (state_q)
            ST_IDLE: begin
                code_d = '0;
                len_d  = '0;
                if (table_ready) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    code_d = nextCode;
                    len_d  = nextLen;
                    if (eobHit) begin
                        symData_d  = INDEX_BIT'(256);
                        symLast_d  = 1'b1;
                        symValid_d = 1'b1;
                        state_d    = ST_EMIT;
                    end else if (tableHit) begin
                        addr_d  = nextCode[ADDR_BIT-1:0];
                        state_d = ST_READ;
                    end else if (maxLen) begin
`ifdef HUFF_ERR_EN
                        state_d = ST_ERR;
`else
                        code_d = '0;
                        len_d  = '0;
`endif
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                symData_d  = table_douta;
                symLast_d  = (table_douta == INDEX_BIT'(256));
                symValid_d = 1'b1;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (sym_ready) begin
                    symValid_d = 1'b0;
                    code_d     = '0;
                    len_d      = '0;
                    state_d    = symLast_q ? ST_DONE : ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
`ifdef HUFF_ERR_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bit_ready = (state_q == ST_SHIFT);
        table_ena = (state_q == ST_READ);
        done      = (state_q == ST_DONE);
`ifdef HUFF_ERR_EN
        err       = (state_q == ST_ERR);
`else
        err       = 1'b0;
`endif
    end

    assign table_wea  = 1'b0;
    assign table_addr = addr_q;
    assign sym_data   = symData_q;
    assign sym_valid  = symValid_q;
    assign sym_last   = symLast_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: directed scenarios plus random codeword streams, checked
// against a codeword dictionary enumerated from the canonical ranges and the table RAM contents.
module tb_huffman_decoder;

    localparam int ADDR_BIT  = 7;
    localparam int INDEX_BIT = 9;
    localparam int CODE_BIT  = 15;
    localparam int LEN_BIT   = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   table_ready;
    logic [16*CODE_BIT-1:0] first_codes;
    logic [16*CODE_BIT-1:0] limit_codes;
    logic [CODE_BIT-1:0]    eob_code;
    logic [LEN_BIT-1:0]     eob_length;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   bit_ready;
    logic [ADDR_BIT-1:0]    table_addr;
    logic                   table_ena;
    logic                   table_wea;
    logic [INDEX_BIT-1:0]   table_douta;
    logic [INDEX_BIT-1:0]   sym_data;
    logic                   sym_valid;
    logic                   sym_ready;
    logic                   sym_last;
    logic                   done;
    logic                   err;

    huffman_decoder #(
        .ADDR_BIT(ADDR_BIT), .INDEX_BIT(INDEX_BIT), .CODE_BIT(CODE_BIT), .LEN_BIT(LEN_BIT)
    ) dut (
        .clock(clock), .reset(reset), .table_ready(table_ready),
        .first_codes(first_codes), .limit_codes(limit_codes),
        .eob_code(eob_code), .eob_length(eob_length),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .table_addr(table_addr), .table_ena(table_ena), .table_wea(table_wea),
        .table_douta(table_douta),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_last(sym_last), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Synchronous-read table RAM: data appears one cycle after the enable.
    logic [INDEX_BIT-1:0] ram [0:127];
    always @(posedge clock) begin
        if (table_ena) table_douta <= ram[table_addr];
    end

    typedef struct {
        int len;
        int code;
        int sym;
    } codeword_t;

    codeword_t dict[$];
    int        expQ[$];
    int        firstArr[16];
    int        limitArr[16];
    int        eobLen;
    int        eobCode;

    int   nChecks = 0;
    int   nFails = 0;
    int   enaCount = 0;
    logic randomReady = 1'b0;
    logic holdPending = 1'b0;
    int   heldData;
    int   heldLast;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive the range arrays to the DUT and enumerate every codeword they define.
    task automatic loadTable();
        dict.delete();
        for (int l = 0; l < 16; l++) begin
            first_codes[l*CODE_BIT +: CODE_BIT] = CODE_BIT'(firstArr[l]);
            limit_codes[l*CODE_BIT +: CODE_BIT] = CODE_BIT'(limitArr[l]);
        end
        eob_code   = CODE_BIT'(eobCode);
        eob_length = LEN_BIT'(eobLen);
        for (int l = 1; l < 16; l++) begin
            for (int c = firstArr[l]; c < limitArr[l]; c++) begin
                if (!(l == eobLen && c == eobCode)) begin
                    codeword_t w;
                    w.len  = l;
                    w.code = c;
                    w.sym  = int'(ram[c % 128]);
                    dict.push_back(w);
                end
            end
        end
    endtask

    task automatic clearTable();
        for (int l = 0; l < 16; l++) begin
            firstArr[l] = 0;
            limitArr[l] = 0;
        end
        for (int i = 0; i < 128; i++) ram[i] = '0;
    endtask

    task automatic setTableA(input logic withLen3);
        clearTable();
        firstArr[2] = 0; limitArr[2] = 3;
        if (withLen3) begin
            firstArr[3] = 6; limitArr[3] = 8;
        end
        eobLen = 2; eobCode = 2;
        ram[0] = 9'd65; ram[1] = 9'd66; ram[6] = 9'd67; ram[7] = 9'd68;
        loadTable();
    endtask

    task automatic setTableB();
        clearTable();
        firstArr[3] = 0;   limitArr[3] = 2;
        firstArr[4] = 4;   limitArr[4] = 10;
        firstArr[5] = 20;  limitArr[5] = 23;
        firstArr[6] = 46;  limitArr[6] = 46;
        firstArr[7] = 92;  limitArr[7] = 96;
        firstArr[8] = 192; limitArr[8] = 194;
        eobLen = 5; eobCode = 22;
        for (int i = 0; i < 128; i++) ram[i] = INDEX_BIT'(300 + i);
        loadTable();
    endtask

    task automatic resetDut();
        reset = 1'b1;
        bit_valid = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        int budget = 0;
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clock);
        while (!bit_ready && budget < 50) begin
            budget++;
            @(negedge clock);
        end
        checkOutput("bitAccepted", int'(bit_ready), 1);
        @(posedge clock); #1;
        bit_valid = 1'b0;
    endtask

    task automatic sendCode(input int code, input int len, input int gapMax);
        for (int k = len - 1; k >= 0; k--) begin
            if (gapMax > 0) begin
                repeat ($urandom_range(gapMax, 0)) begin @(posedge clock); #1; end
            end
            sendBit(code[k]);
        end
    endtask

    task automatic applyStimulus(input codeword_t w, input int gapMax);
        expQ.push_back(w.sym);
        sendCode(w.code, w.len, gapMax);
    endtask

    // Called one cycle after the last code bit was accepted.
    task automatic expectTableSymbol(input int addr, input int sym);
        checkOutput("tableEnaT1", int'(table_ena), 1);
        checkOutput("tableAddrT1", int'(table_addr), addr);
        checkOutput("bitReadyRead", int'(bit_ready), 0);
        checkOutput("symValidT1", int'(sym_valid), 0);
        @(posedge clock); #1;
        checkOutput("tableEnaT2", int'(table_ena), 0);
        checkOutput("bitReadyCapt", int'(bit_ready), 0);
        checkOutput("symValidT2", int'(sym_valid), 0);
        @(posedge clock); #1;
        checkOutput("symValidT3", int'(sym_valid), 1);
        checkOutput("symDataT3", int'(sym_data), sym);
        checkOutput("symLastT3", int'(sym_last), 0);
        checkOutput("bitReadyEmit", int'(bit_ready), 0);
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (expQ.size() != 0 && budget < 500) begin
            @(posedge clock); #1;
            budget++;
        end
        checkOutput("queueDrained", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bitReady"}, int'(bit_ready), 0);
        checkOutput({tag, "_tableAddr"}, int'(table_addr), 0);
        checkOutput({tag, "_tableEna"}, int'(table_ena), 0);
        checkOutput({tag, "_tableWea"}, int'(table_wea), 0);
        checkOutput({tag, "_symData"}, int'(sym_data), 0);
        checkOutput({tag, "_symValid"}, int'(sym_valid), 0);
        checkOutput({tag, "_symLast"}, int'(sym_last), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_err"}, int'(err), 0);
    endtask

    task automatic runRandomEpisodes(input int episodes);
        for (int ep = 0; ep < episodes; ep++) begin
            int n;
            if (ep % 2 == 0) setTableA(1'b1);
            else setTableB();
            resetDut();
            table_ready = 1'b1;
            randomReady = 1'b1;
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) begin
                int idx;
                idx = int'($urandom_range(dict.size() - 1, 0));
                applyStimulus(dict[idx], 2);
            end
            expQ.push_back(256);
            sendCode(eobCode, eobLen, 2);
            waitDrain();
            checkOutput("randDone", int'(done), 1);
            checkOutput("randBitReadyDone", int'(bit_ready), 0);
        end
        randomReady = 1'b0;
        sym_ready = 1'b1;
    endtask

    initial begin
        int enaBefore;
        reset = 1'b1;
        table_ready = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        sym_ready = 1'b0;
        first_codes = '0;
        limit_codes = '0;
        eob_code = '0;
        eob_length = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clock);
                    if (table_ena) enaCount++;
                    if (holdPending && !reset) begin
                        checkOutput("emitHoldValid", int'(sym_valid), 1);
                        checkOutput("emitHoldData", int'(sym_data), heldData);
                        checkOutput("emitHoldLast", int'(sym_last), heldLast);
                    end
                    holdPending = sym_valid && !sym_ready && !reset;
                    heldData = int'(sym_data);
                    heldLast = int'(sym_last);
                    if (sym_valid && sym_ready && !reset) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpectedSym", int'(sym_data), -1);
                        end else begin
                            int exp;
                            exp = expQ.pop_front();
                            checkOutput("sbSymData", int'(sym_data), exp);
                            checkOutput("sbSymLast", int'(sym_last), int'(exp == 256));
                        end
                    end
                end
            end
            begin : readyDriver
                forever begin
                    @(posedge clock); #2;
                    if (randomReady) sym_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join_none

        // Reset state and IDLE behaviour.
        setTableA(1'b1);
        resetDut();
        checkAllZero("reset");
        repeat (2) begin @(posedge clock); #1; end
        checkOutput("idleBitReady", int'(bit_ready), 0);
        table_ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("shiftBitReady", int'(bit_ready), 1);
        table_ready = 1'b0;

        // Scenario 1: 00 -> 65.
        sym_ready = 1'b1;
        expQ.push_back(65);
        sendBit(1'b0); sendBit(1'b0);
        expectTableSymbol(0, 65);
        @(posedge clock); #1;
        checkOutput("s1BitReadyAfter", int'(bit_ready), 1);
        checkOutput("s1SymValidAfter", int'(sym_valid), 0);

        // Scenario 2: 110 -> 67, 111 -> 68.
        expQ.push_back(67);
        sendCode(6, 3, 0);
        expectTableSymbol(6, 67);
        @(posedge clock); #1;
        expQ.push_back(68);
        sendCode(7, 3, 0);
        expectTableSymbol(7, 68);
        @(posedge clock); #1;
        checkOutput("s2BitReadyAfter", int'(bit_ready), 1);

        // Scenario 4: 01 -> 66 with a stalled consumer.
        sym_ready = 1'b0;
        expQ.push_back(66);
        sendCode(1, 2, 0);
        expectTableSymbol(1, 66);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checkOutput("s4StallValid", int'(sym_valid), 1);
            checkOutput("s4StallData", int'(sym_data), 66);
            checkOutput("s4StallBitReady", int'(bit_ready), 0);
        end
        sym_ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("s4ResumeBitReady", int'(bit_ready), 1);
        checkOutput("s4ResumeSymValid", int'(sym_valid), 0);
        checkOutput("s4Drained", expQ.size(), 0);

        // Scenario 3: 10 -> end of block, no table access.
        enaBefore = enaCount;
        expQ.push_back(256);
        sendCode(2, 2, 0);
        checkOutput("s3SymValid", int'(sym_valid), 1);
        checkOutput("s3SymData", int'(sym_data), 256);
        checkOutput("s3SymLast", int'(sym_last), 1);
        @(posedge clock); #1;
        checkOutput("s3Done", int'(done), 1);
        checkOutput("s3BitReady", int'(bit_ready), 0);
        bit_in = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            checkOutput("s3NoAcceptBitReady", int'(bit_ready), 0);
            checkOutput("s3DoneHeld", int'(done), 1);
        end
        bit_valid = 1'b0;
        checkOutput("s3NoTableRead", enaCount, enaBefore);
        checkOutput("s3Drained", expQ.size(), 0);

        // Scenario 5: fifteen ones never match.
        setTableA(1'b0);
        resetDut();
        table_ready = 1'b1;
        for (int i = 0; i < 15; i++) sendBit(1'b1);
`ifdef HUFF_ERR_EN
        checkOutput("s5Err", int'(err), 1);
        checkOutput("s5BitReady", int'(bit_ready), 0);
        checkOutput("s5SymValid", int'(sym_valid), 0);
        repeat (3) begin @(posedge clock); #1; end
        checkOutput("s5ErrHeld", int'(err), 1);
`else
        checkOutput("s5Err", int'(err), 0);
        checkOutput("s5BitReady", int'(bit_ready), 1);
        expQ.push_back(65);
        sendCode(0, 2, 0);
        expectTableSymbol(0, 65);
        waitDrain();
`endif

        // Scenario 6: reset while the table read is in flight.
        setTableA(1'b1);
        resetDut();
        table_ready = 1'b1;
        sendCode(0, 2, 0);
        checkOutput("s6TableEnaPre", int'(table_ena), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        checkAllZero("s6Reset");
        reset = 1'b0;
        expQ.push_back(66);
        sendCode(1, 2, 0);
        expectTableSymbol(1, 66);
        waitDrain();

        // Long code whose value exceeds the table address width.
        setTableB();
        resetDut();
        table_ready = 1'b1;
        expQ.push_back(364);
        sendCode(192, 8, 0);
        expectTableSymbol(64, 364);
        waitDrain();
        expQ.push_back(256);
        sendCode(22, 5, 0);
        waitDrain();
        checkOutput("bDone", int'(done), 1);

        runRandomEpisodes(16);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Canonical Huffman symbol decoder for the DEFLATE decompress path. It consumes the compressed bitstream one bit per cycle, MSB of each code first. It matches the growing code against per-length canonical code ranges, then reads the symbol from the Huffman table RAM already filled by the table builder, addressed by code value. End-of-block is recognised directly from the builder's `eob_code`/`eob_length`, without a table read, and terminates decoding.

## Interface
- `ADDR_BIT`, default 7: Huffman table address width.
- `INDEX_BIT`, default 9: symbol width.
- `CODE_BIT`, default 15: code register width.
- `LEN_BIT`, default 4: code length width; legal lengths are 1..15.

Ports:
- `clock`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `table_ready`, in, 1: level; table build complete (builder `sig_end`).
- `first_codes`, in, 16*CODE_BIT: first canonical code of length L at `[L*CODE_BIT +: CODE_BIT]`; L=0 is unused.
- `limit_codes`, in, 16*CODE_BIT: first code plus count for length L. limit==first means no codes of that length.
- `eob_code`, in, 15: code of symbol 256.
- `eob_length`, in, 4: length of symbol 256.
- `bit_in`, in, 1: stream bit.
- `bit_valid`, in, 1: `bit_in` valid.
- `bit_ready`, out, 1: decoder accepts a bit this cycle.
- `table_addr`, out, ADDR_BIT: table read address.
- `table_ena`, out, 1: table enable.
- `table_wea`, out, 1: held 0.
- `table_douta`, in, INDEX_BIT: table read data, valid 1 cycle after `table_ena`.
- `sym_data`, out, INDEX_BIT: decoded symbol.
- `sym_valid`, out, 1: symbol valid.
- `sym_ready`, in, 1: downstream accepts symbol.
- `sym_last`, out, 1: with `sym_valid`, marks symbol 256.
- `done`, out, 1: EOB delivered.
- `err`, out, 1: invalid code (see Configuration).

## Operation
States:
- IDLE:
  - Clears `code` and `len`.
  - Goes to SHIFT when `table_ready`=1.
- SHIFT:
  - `bit_ready`=1. A bit is accepted when `bit_valid && bit_ready`.
  - On accept: nc = {code[13:0], bit_in}, nl = len+1. Registered as `code`/`len`.
  - EOB match: nl==`eob_length` and nc==`eob_code`. Go to EMIT with `sym_data`=256 and `sym_last`=1.
  - Table match: first[nl] <= nc < limit[nl], unsigned 15-bit compare. Go to READ with `table_addr`=nc[ADDR_BIT-1:0] and `table_ena`=1.
  - The EOB check has priority over the table check.
  - No match and nl==15: invalid code (see Configuration).
  - No match otherwise: stay in SHIFT.
- READ:
  - One cycle. `table_ena` drops to 0.
  - Goes to CAPT.
- CAPT:
  - Registers `table_douta` into `sym_data`.
  - Sets `sym_valid`=1 and `sym_last`=(`table_douta`==256).
  - Goes to EMIT.
- EMIT:
  - `sym_valid`=1. `sym_data`/`sym_last` are held stable until `sym_ready`.
  - On handshake: clear `sym_valid`, `code` and `len`.
  - Then go to DONE if `sym_last`, else SHIFT.
- DONE:
  - `done`=1, `bit_ready`=0.
  - Holds until reset.
- ERR: only exists with HUFF_ERR_EN (see Configuration).

Handshake and width rules:
- `bit_ready` is 0 in every state except SHIFT.
- Bits presented while `bit_ready`=0 are not consumed.
- `len` saturates by design at 15, because the decision is made at nl==15.
- `table_addr` truncates the code to ADDR_BIT bits.

## Timing
- Reset value of every output is 0: `bit_ready`, `table_addr`, `table_ena`, `table_wea`, `sym_data`, `sym_valid`, `sym_last`, `done`, `err`. State returns to IDLE.
- Throughput: one bit per cycle while in SHIFT.
- Latency, table symbol: last bit accepted at cycle T.
  - `table_ena`=1 at T+1.
  - `table_douta` sampled at T+2.
  - `sym_valid`=1 at T+3.
- Latency, EOB: `sym_valid`=1 at T+1, with no table access.
- After a symbol handshake at cycle H: `bit_ready`=1 at H+1 (SHIFT), or `done`=1 at H+1 (DONE).
- `table_ready` is sampled only in IDLE. Deassertion afterwards is ignored.
- Reset mid-operation: everything returns to reset values the next cycle.
  - The in-flight symbol and partial code are discarded.
  - A pending table read result is ignored.
- `sym_ready` high while `sym_valid`=0 has no effect.

## Configuration
HUFF_ERR_EN:
- Defined:
  - No match at nl==15 goes to state ERR: `err`=1, `bit_ready`=0, `sym_valid`=0.
  - ERR holds until reset.
- Undefined:
  - No ERR state; `err` is tied to 0.
  - No match at nl==15 clears `code`/`len` and stays in SHIFT, resynchronising on the next bit.
  - The offending bits are dropped silently.

## Test plan
Common table for scenarios 1–4:
- Length 2: first=0, limit=3.
- Length 3: first=6, limit=8.
- All other lengths: empty.
- EOB: `eob_code`=2, `eob_length`=2.
- RAM contents: [0]=65, [1]=66, [6]=67, [7]=68.

Scenarios:
1. `table_ready`=1, bits 0,0 with `sym_ready`=1 -> `table_addr`=0 at T+1; `sym_data`=65 and `sym_valid` at T+3; `sym_last`=0.
2. Bits 1,1,0 then 1,1,1 -> symbols 67 then 68; `table_addr` 6 then 7; `bit_ready`=0 during READ/CAPT/EMIT.
3. Bits 1,0 -> `sym_data`=256, `sym_last`=1 at T+1; `table_ena` never asserted; `done`=1 after the handshake; later bits are not accepted.
4. Bits 0,1 with `sym_ready` low for 5 cycles -> `sym_data`=66 stable for all 5 cycles; `bit_ready`=0; resumes 1 cycle after handshake.
5. All lengths empty except length 2 as above; feed 15 ones.
   - With HUFF_ERR_EN: `err`=1 after the 15th bit and `bit_ready`=0.
   - Without HUFF_ERR_EN: a following 0,0 decodes to 65.
6. Assert `reset` at the cycle `table_ena`=1 -> all outputs 0 next cycle; no `sym_valid`; after release with `table_ready`=1, bits 0,1 decode to 66.
